// File: rtl/cache_sram_arbiter_pkg.sv
// Shared types for the I/D cache SRAM-bus arbiter.
// Holds the FSM encoding, the master IDs and the forwarded request bundle.
package cache_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_t;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/cache_sram_arbiter_pick2.sv
// Combinational 2-way picker, req indexed by master ID; 0-cycle latency.
// Fixed priority favours D; round-robin hands a tie to the master that was not served last.
module arb_pick2
  import cache_sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       win
);

  always_comb begin
    win = MST_I;
    if (req[MST_D] && req[MST_I]) begin
      win = rr_en ? ~last : MST_D;
    end else if (req[MST_D]) begin
      win = MST_D;
    end
  end

endmodule

// File: rtl/cache_sram_arbiter.sv
// Shares one SRAM-like bus between I-cache and D-cache, one transaction in flight.
// Winner is forwarded in the same cycle; the loser sees addr_ok=0 until the owner's data_ok.
module cache_sram_arbiter
  import cache_sram_arbiter_pkg::*;
#(
  parameter bit RR_EN     = 1'b0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [1:0]           i_size,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          i_rdata,
  output logic                 i_addr_ok,
  output logic                 i_data_ok,

  input  logic                 d_req,
  input  logic                 d_wr,
  input  logic [1:0]           d_size,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic [31:0]          d_rdata,
  output logic                 d_addr_ok,
  output logic                 d_data_ok,

  output logic                 m_req,
  output logic                 m_wr,
  output logic [1:0]           m_size,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_addr_ok,
  input  logic                 m_data_ok,

  output logic [CNT_WIDTH-1:0] i_cnt,
  output logic [CNT_WIDTH-1:0] d_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  arb_state_t state;
  logic       owner;
  logic       last_owner;
  logic       win;
  logic       any_req;
  logic       cur_owner;
  logic       addr_phase;
  logic       data_phase;
  logic       drive;
  sram_req_t  i_fld;
  sram_req_t  d_fld;
  sram_req_t  m_fld;

  arb_pick2 u_pick (
    .req   ({d_req, i_req}),
    .last  (last_owner),
    .rr_en (RR_EN),
    .win   (win)
  );

  assign any_req = i_req | d_req;
  assign i_fld   = '{wr: i_wr, size: i_size, addr: i_addr, wdata: i_wdata};
  assign d_fld   = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata};

  // In IDLE the grant is the live pick; afterwards only the latched owner counts.
  assign cur_owner  = (state == ARB_IDLE) ? win : owner;
  assign addr_phase = !rst && (((state == ARB_IDLE) && any_req) || (state == ARB_ADDR));
  assign data_phase = !rst && (state == ARB_DATA);
  assign drive      = addr_phase || data_phase;

  always_comb begin
    m_fld = '0;
    if (drive) begin
      m_fld = (cur_owner == MST_D) ? d_fld : i_fld;
    end
  end

  assign m_req   = addr_phase;
  assign m_wr    = m_fld.wr;
  assign m_size  = m_fld.size;
  assign m_addr  = m_fld.addr;
  assign m_wdata = m_fld.wdata;

  assign i_addr_ok = m_addr_ok && addr_phase && (cur_owner == MST_I);
  assign d_addr_ok = m_addr_ok && addr_phase && (cur_owner == MST_D);
  assign i_data_ok = m_data_ok && data_phase && (owner == MST_I);
  assign d_data_ok = m_data_ok && data_phase && (owner == MST_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= MST_D;
      last_owner <= MST_D;
      i_cnt      <= '0;
      d_cnt      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner <= win;
            state <= m_addr_ok ? ARB_DATA : ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (m_addr_ok) begin
            state <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (m_data_ok) begin
            state      <= ARB_IDLE;
            last_owner <= owner;
            if (owner == MST_D) begin
              d_cnt <= d_cnt + CNT_ONE;
            end else begin
              i_cnt <= i_cnt + CNT_ONE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Directed bench for cache_sram_arbiter: fixed-priority instance walked through a cycle table,
// round-robin instance (2-bit counters) checked for grant alternation and counter wrap.
module tb_cache_sram_arbiter;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  localparam logic [31:0] IW = 32'h1111_1111;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;
  localparam logic [31:0] RD = 32'h3C08_BFAF;
  localparam int          NV = 18;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0, i_cnt0, d_cnt0;
  logic        i_addr_ok0, i_data_ok0, d_addr_ok0, d_data_ok0, m_req0, m_wr0;
  logic [1:0]  m_size0;

  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        i_addr_ok1, i_data_ok1, d_addr_ok1, d_data_ok1, m_req1, m_wr1;
  logic [1:0]  m_size1, i_cnt1, d_cnt1;

  cache_sram_arbiter #(.RR_EN(1'b0), .CNT_WIDTH(32)) u_fix (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata0), .i_addr_ok(i_addr_ok0), .i_data_ok(i_data_ok0),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_addr_ok(d_addr_ok0), .d_data_ok(d_data_ok0),
    .m_req(m_req0), .m_wr(m_wr0), .m_size(m_size0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .i_cnt(i_cnt0), .d_cnt(d_cnt0)
  );

  cache_sram_arbiter #(.RR_EN(1'b1), .CNT_WIDTH(2)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata1), .i_addr_ok(i_addr_ok1), .i_data_ok(i_data_ok1),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_addr_ok(d_addr_ok1), .d_data_ok(d_data_ok1),
    .m_req(m_req1), .m_wr(m_wr1), .m_size(m_size1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .i_cnt(i_cnt1), .d_cnt(d_cnt1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic dr,
                       input logic aok, input logic dok);
    rst       = r;
    i_req     = ir;
    d_req     = dr;
    m_addr_ok = aok;
    m_data_ok = dok;
  endtask

  typedef struct {
    logic        rst, ir, dr, aok, dok;
    logic        mreq;
    logic [31:0] maddr, mwd;
    logic        iaok, idok, daok, ddok;
    logic [31:0] icnt, dcnt;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    // rst ir dr aok dok | mreq maddr mwd | iaok idok daok ddok | icnt dcnt
    tbl[0]  = '{1,1,1,1,1, 0, 0,  0,  0,0,0,0, 0,0};  // reset masks all outputs
    tbl[1]  = '{0,1,0,1,0, 1, IA, IW, 1,0,0,0, 0,0};  // I read, addr_ok in IDLE
    tbl[2]  = '{0,0,0,0,0, 0, IA, IW, 0,0,0,0, 0,0};
    tbl[3]  = '{0,0,0,0,0, 0, IA, IW, 0,0,0,0, 0,0};
    tbl[4]  = '{0,0,0,0,1, 0, IA, IW, 0,1,0,0, 0,0};  // I data_ok cyc3
    tbl[5]  = '{0,0,0,0,0, 0, 0,  0,  0,0,0,0, 1,0};
    tbl[6]  = '{0,0,0,0,1, 0, 0,  0,  0,0,0,0, 1,0};  // spurious data_ok in IDLE
    tbl[7]  = '{0,1,1,0,0, 1, DA, DW, 0,0,0,0, 1,0};  // tie: D wins
    tbl[8]  = '{0,1,1,0,1, 1, DA, DW, 0,0,0,0, 1,0};  // spurious data_ok in ADDR
    tbl[9]  = '{0,1,1,1,0, 1, DA, DW, 0,0,1,0, 1,0};
    tbl[10] = '{0,1,0,1,0, 0, DA, DW, 0,0,0,0, 1,0};  // addr_ok in DATA routes nowhere
    tbl[11] = '{0,1,0,0,1, 0, DA, DW, 0,0,0,1, 1,0};
    tbl[12] = '{0,1,0,0,0, 1, IA, IW, 0,0,0,0, 1,1};  // I granted right after D done
    tbl[13] = '{0,1,0,1,0, 1, IA, IW, 1,0,0,0, 1,1};
    tbl[14] = '{0,0,0,0,0, 0, IA, IW, 0,0,0,0, 1,1};
    tbl[15] = '{1,1,0,1,1, 0, 0,  0,  0,0,0,0, 1,1};  // reset mid-DATA
    tbl[16] = '{0,1,0,1,0, 1, IA, IW, 1,0,0,0, 0,0};
    tbl[17] = '{0,0,0,0,1, 0, IA, IW, 0,1,0,0, 0,0};

    i_wr = 1'b0; i_size = 2'd2; i_addr = IA; i_wdata = IW;
    d_wr = 1'b1; d_size = 2'd2; d_addr = DA; d_wdata = DW;
    m_rdata = RD;
    drive(1, 1, 1, 1, 1);

    @(posedge clk) #1;
    #3;
    chk("rst m_req",     {31'd0, m_req0},     32'd0);
    chk("rst i_addr_ok", {31'd0, i_addr_ok0}, 32'd0);
    chk("rst d_addr_ok", {31'd0, d_addr_ok0}, 32'd0);
    chk("rst d_data_ok", {31'd0, d_data_ok0}, 32'd0);
    chk("rst m_addr",    m_addr0,             32'd0);
    chk("rst i_cnt",     i_cnt0,              32'd0);
    chk("rst d_cnt",     d_cnt0,              32'd0);
    chk("rst rr m_req",  {31'd0, m_req1},     32'd0);
    @(posedge clk) #1;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].rst, tbl[k].ir, tbl[k].dr, tbl[k].aok, tbl[k].dok);
      #3;
      chk($sformatf("row%0d m_req", k),     {31'd0, m_req0},     {31'd0, tbl[k].mreq});
      chk($sformatf("row%0d m_addr", k),    m_addr0,             tbl[k].maddr);
      chk($sformatf("row%0d m_wdata", k),   m_wdata0,            tbl[k].mwd);
      chk($sformatf("row%0d i_addr_ok", k), {31'd0, i_addr_ok0}, {31'd0, tbl[k].iaok});
      chk($sformatf("row%0d i_data_ok", k), {31'd0, i_data_ok0}, {31'd0, tbl[k].idok});
      chk($sformatf("row%0d d_addr_ok", k), {31'd0, d_addr_ok0}, {31'd0, tbl[k].daok});
      chk($sformatf("row%0d d_data_ok", k), {31'd0, d_data_ok0}, {31'd0, tbl[k].ddok});
      chk($sformatf("row%0d i_cnt", k),     i_cnt0,              tbl[k].icnt);
      chk($sformatf("row%0d d_cnt", k),     d_cnt0,              tbl[k].dcnt);
      if (tbl[k].idok) chk($sformatf("row%0d i_rdata", k), i_rdata0, RD);
      if (tbl[k].ddok) chk($sformatf("row%0d d_rdata", k), d_rdata0, RD);
      if (tbl[k].daok) begin
        chk($sformatf("row%0d m_wr", k),   {31'd0, m_wr0},   32'd1);
        chk($sformatf("row%0d m_size", k), {30'd0, m_size0}, 32'd2);
      end
      @(posedge clk) #1;
    end
    #3;
    chk("post-table i_cnt", i_cnt0, 32'd1);
    chk("post-table d_cnt", d_cnt0, 32'd0);

    // Both masters requesting continuously: round-robin alternates, fixed priority starves I.
    drive(1, 0, 0, 0, 0);
    @(posedge clk) #1;
    for (int t = 0; t < 8; t++) begin
      logic exp_d;
      exp_d = (t % 2) == 1;
      drive(0, 1, 1, 1, 0);
      #3;
      chk($sformatf("rr%0d i_addr_ok", t),  {31'd0, i_addr_ok1}, {31'd0, ~exp_d});
      chk($sformatf("rr%0d d_addr_ok", t),  {31'd0, d_addr_ok1}, {31'd0, exp_d});
      chk($sformatf("rr%0d m_addr", t),     m_addr1,             exp_d ? DA : IA);
      chk($sformatf("fix%0d d_addr_ok", t), {31'd0, d_addr_ok0}, 32'd1);
      chk($sformatf("fix%0d i_addr_ok", t), {31'd0, i_addr_ok0}, 32'd0);
      @(posedge clk) #1;
      drive(0, 1, 1, 0, 1);
      #3;
      chk($sformatf("rr%0d i_data_ok", t),  {31'd0, i_data_ok1}, {31'd0, ~exp_d});
      chk($sformatf("rr%0d d_data_ok", t),  {31'd0, d_data_ok1}, {31'd0, exp_d});
      @(posedge clk) #1;
      if (t == 3) begin
        #3;
        chk("rr i_cnt after 4", {30'd0, i_cnt1}, 32'd2);
        chk("rr d_cnt after 4", {30'd0, d_cnt1}, 32'd2);
      end
    end
    drive(0, 0, 0, 0, 0);
    #3;
    chk("rr i_cnt wrap", {30'd0, i_cnt1}, 32'd0);
    chk("rr d_cnt wrap", {30'd0, d_cnt1}, 32'd0);
    chk("fix d_cnt 8",   d_cnt0,          32'd8);
    chk("fix i_cnt 0",   i_cnt0,          32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
